// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: shared widths, funct3 codes, s3 read-data select codes and FSM encoding
package mem_access_stage_pkg;
  localparam int DATA_BITS = 32;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2} state_e;
  typedef enum logic [2:0] {
    SEL_PASSTHROUGH          = 3'd0,
    SEL_LOW_BYTE             = 3'd1,
    SEL_LOW_BYTE_SIGNED      = 3'd2,
    SEL_LOW_HALF_WORD        = 3'd3,
    SEL_LOW_HALF_WORD_SIGNED = 3'd4
  } rdata_sel_e;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: data-memory bus (request valid/ready/addr/we/wdata/wmask, response valid/data); master = stage, slave = memory
interface mem_access_stage_if;
  import mem_access_stage_pkg::*;
  logic                 dmem_req_valid;
  logic                 dmem_req_ready;
  logic [DATA_BITS-1:0] dmem_req_addr;
  logic                 dmem_req_we;
  logic [DATA_BITS-1:0] dmem_req_wdata;
  logic [3:0]           dmem_req_wmask;
  logic                 dmem_resp_valid;
  logic [DATA_BITS-1:0] dmem_resp_data;
  modport master (
    output dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_wdata, dmem_req_wmask,
    input  dmem_req_ready, dmem_resp_valid, dmem_resp_data
  );
  modport slave (
    input  dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_wdata, dmem_req_wmask,
    output dmem_req_ready, dmem_resp_valid, dmem_resp_data
  );
endinterface

// File: rtl/mem_access_stage_store_align.sv
// mem_access_stage_store_align: comb decode of op (is_load/is_store/funct3/addr_lo/wdata) into aligned wdata, wmask, load select and illegal flag
module mem_access_stage_store_align
  import mem_access_stage_pkg::*;
(
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic [2:0]           funct3,
  input  logic [1:0]           addr_lo,
  input  logic [DATA_BITS-1:0] wdata,
  output logic [DATA_BITS-1:0] wdata_al,
  output logic [3:0]           wmask,
  output rdata_sel_e           sel,
  output logic                 illegal
);
  logic size_b, size_h, size_w, bad_f3, misalign;
  always_comb begin
    size_b   = funct3[1:0] == 2'b00;
    size_h   = funct3[1:0] == 2'b01;
    size_w   = funct3[1:0] == 2'b10;
    bad_f3   = is_store ? (funct3[2] || funct3[1:0] == 2'b11) : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
    misalign = (size_h && addr_lo[0]) || (size_w && addr_lo != 2'b00);
    illegal  = (is_load && is_store) || ((is_load || is_store) && (bad_f3 || misalign));
    wdata_al = size_b ? {4{wdata[7:0]}} : size_h ? {2{wdata[15:0]}} : wdata;
    wmask    = !is_store ? 4'b0000 : size_b ? 4'b0001 << addr_lo : size_h ? 4'b0011 << addr_lo : 4'b1111;
    sel      = funct3 == F3_LB  ? SEL_LOW_BYTE_SIGNED :
               funct3 == F3_LH  ? SEL_LOW_HALF_WORD_SIGNED :
               funct3 == F3_LBU ? SEL_LOW_BYTE :
               funct3 == F3_LHU ? SEL_LOW_HALF_WORD : SEL_PASSTHROUGH;
  end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory stage; s2 op in (valid/ready), dmem bus via interface, single-cycle s3 result pulse out
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int CPU_DATA_BITS = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s2_valid,
  output logic                     s2_ready,
  input  logic                     s2_is_load,
  input  logic                     s2_is_store,
  input  logic [2:0]               s2_funct3,
  input  logic [CPU_DATA_BITS-1:0] s2_addr,
  input  logic [CPU_DATA_BITS-1:0] s2_wdata,
  input  logic [4:0]               s2_rd,
  input  logic                     s2_reg_we,
  mem_access_stage_if.master       dmem,
  output logic                     s3_valid,
  output logic [CPU_DATA_BITS-1:0] s3_rdata,
  output logic [2:0]               s3_rdata_sel,
  output logic [1:0]               byte_select,
  output logic [4:0]               s3_rd,
  output logic                     s3_reg_we,
  output logic                     s3_fault
);
  state_e                   state_q, state_d;
  logic [CPU_DATA_BITS-1:0] addr_q, addr_d, wdata_q, wdata_d, s3_rdata_q, s3_rdata_d;
  logic [3:0]               wmask_q, wmask_d;
  logic [4:0]               rd_q, rd_d, s3_rd_q, s3_rd_d;
  logic                     store_q, store_d, reg_we_q, reg_we_d;
  rdata_sel_e               sel_q, sel_d, s3_sel_q, s3_sel_d;
  logic [1:0]               s3_bsel_q, s3_bsel_d;
  logic                     s3_valid_q, s3_valid_d, s3_fault_q, s3_fault_d, s3_reg_we_q, s3_reg_we_d;
  logic [CPU_DATA_BITS-1:0] sa_wdata;
  logic [3:0]               sa_wmask;
  rdata_sel_e               sa_sel;
  logic                     sa_illegal, accept, mem_op, store_done, load_done;

  mem_access_stage_store_align u_store_align (
    .is_load  (s2_is_load),
    .is_store (s2_is_store),
    .funct3   (s2_funct3),
    .addr_lo  (s2_addr[1:0]),
    .wdata    (s2_wdata),
    .wdata_al (sa_wdata),
    .wmask    (sa_wmask),
    .sel      (sa_sel),
    .illegal  (sa_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = (accept && mem_op && !sa_illegal) ? ST_REQ : ST_IDLE;
      ST_REQ:  state_d = dmem.dmem_req_ready ? (store_q ? ST_IDLE : ST_WAIT) : ST_REQ;
      ST_WAIT: state_d = dmem.dmem_resp_valid ? ST_IDLE : ST_WAIT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s2_ready             = state_q == ST_IDLE;
    accept               = s2_ready && s2_valid;
    mem_op               = s2_is_load || s2_is_store;
    store_done           = state_q == ST_REQ && dmem.dmem_req_ready && store_q;
    load_done            = state_q == ST_WAIT && dmem.dmem_resp_valid;
    dmem.dmem_req_valid  = state_q == ST_REQ;
    dmem.dmem_req_addr   = {addr_q[CPU_DATA_BITS-1:2], 2'b00};
    dmem.dmem_req_we     = store_q;
    dmem.dmem_req_wdata  = wdata_q;
    dmem.dmem_req_wmask  = wmask_q;
    s3_valid             = s3_valid_q;
    s3_fault             = s3_fault_q;
    s3_rdata             = s3_rdata_q;
    s3_rdata_sel         = s3_sel_q;
    byte_select          = s3_bsel_q;
    s3_rd                = s3_rd_q;
    s3_reg_we            = s3_reg_we_q;
  end

  always_comb begin
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    rd_d        = rd_q;
    store_d     = store_q;
    reg_we_d    = reg_we_q;
    sel_d       = sel_q;
    s3_valid_d  = 1'b0;
    s3_fault_d  = 1'b0;
    s3_rdata_d  = s3_rdata_q;
    s3_sel_d    = s3_sel_q;
    s3_bsel_d   = s3_bsel_q;
    s3_rd_d     = s3_rd_q;
    s3_reg_we_d = s3_reg_we_q;
    if (accept && sa_illegal) begin
      s3_valid_d  = 1'b1;
      s3_fault_d  = 1'b1;
      s3_reg_we_d = 1'b0;
    end else if (accept && !mem_op) begin
      s3_valid_d  = 1'b1;
      s3_rdata_d  = s2_addr;
      s3_sel_d    = SEL_PASSTHROUGH;
      s3_bsel_d   = 2'b00;
      s3_rd_d     = s2_rd;
      s3_reg_we_d = s2_reg_we;
    end else if (accept) begin
      addr_d   = s2_addr;
      wdata_d  = sa_wdata;
      wmask_d  = sa_wmask;
      rd_d     = s2_rd;
      store_d  = s2_is_store;
      reg_we_d = s2_reg_we;
      sel_d    = sa_sel;
    end
    if (store_done) begin
      s3_valid_d  = 1'b1;
      s3_reg_we_d = 1'b0;
      s3_bsel_d   = 2'b00;
    end
    if (load_done) begin
      s3_valid_d  = 1'b1;
      s3_rdata_d  = dmem.dmem_resp_data;
      s3_sel_d    = sel_q;
      s3_bsel_d   = addr_q[1:0];
      s3_rd_d     = rd_q;
      s3_reg_we_d = reg_we_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      rd_q        <= '0;
      store_q     <= 1'b0;
      reg_we_q    <= 1'b0;
      sel_q       <= SEL_PASSTHROUGH;
      s3_valid_q  <= 1'b0;
      s3_fault_q  <= 1'b0;
      s3_rdata_q  <= '0;
      s3_sel_q    <= SEL_PASSTHROUGH;
      s3_bsel_q   <= 2'b00;
      s3_rd_q     <= '0;
      s3_reg_we_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      rd_q        <= rd_d;
      store_q     <= store_d;
      reg_we_q    <= reg_we_d;
      sel_q       <= sel_d;
      s3_valid_q  <= s3_valid_d;
      s3_fault_q  <= s3_fault_d;
      s3_rdata_q  <= s3_rdata_d;
      s3_sel_q    <= s3_sel_d;
      s3_bsel_q   <= s3_bsel_d;
      s3_rd_q     <= s3_rd_d;
      s3_reg_we_q <= s3_reg_we_d;
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed self-checking bench for mem_access_stage
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;
  logic        clk = 1'b0;
  logic        reset;
  logic        s2_valid, s2_ready, s2_is_load, s2_is_store, s2_reg_we;
  logic [2:0]  s2_funct3;
  logic [31:0] s2_addr, s2_wdata;
  logic [4:0]  s2_rd;
  logic        s3_valid, s3_reg_we, s3_fault;
  logic [31:0] s3_rdata;
  logic [2:0]  s3_rdata_sel;
  logic [1:0]  byte_select;
  logic [4:0]  s3_rd;
  int          checks = 0;
  int          failures = 0;

  mem_access_stage_if dmem ();

  mem_access_stage #(.CPU_DATA_BITS(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .s2_valid     (s2_valid),
    .s2_ready     (s2_ready),
    .s2_is_load   (s2_is_load),
    .s2_is_store  (s2_is_store),
    .s2_funct3    (s2_funct3),
    .s2_addr      (s2_addr),
    .s2_wdata     (s2_wdata),
    .s2_rd        (s2_rd),
    .s2_reg_we    (s2_reg_we),
    .dmem         (dmem.master),
    .s3_valid     (s3_valid),
    .s3_rdata     (s3_rdata),
    .s3_rdata_sel (s3_rdata_sel),
    .byte_select  (byte_select),
    .s3_rd        (s3_rd),
    .s3_reg_we    (s3_reg_we),
    .s3_fault     (s3_fault)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w, input logic [4:0] rd, input logic we);
    s2_valid = 1'b1; s2_is_load = ld; s2_is_store = st; s2_funct3 = f3;
    s2_addr = a; s2_wdata = w; s2_rd = rd; s2_reg_we = we;
    cyc();
    s2_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; s2_valid = 1'b0; s2_is_load = 1'b0; s2_is_store = 1'b0; s2_funct3 = 3'b0;
    s2_addr = '0; s2_wdata = '0; s2_rd = '0; s2_reg_we = 1'b0;
    dmem.dmem_req_ready = 1'b0; dmem.dmem_resp_valid = 1'b0; dmem.dmem_resp_data = '0;
    cyc(); cyc();
    reset = 1'b0;
    checks++; if ({s3_valid, s3_fault, s3_reg_we, s3_rdata, s3_rdata_sel, byte_select, s3_rd} !== 45'd0) begin failures++; $display("FAIL reset_s3 got=%h exp=0", {s3_valid, s3_fault, s3_reg_we, s3_rdata, s3_rdata_sel, byte_select, s3_rd}); end
    checks++; if ({dmem.dmem_req_valid, s2_ready} !== 2'b01) begin failures++; $display("FAIL reset_ctrl got=%b exp=01", {dmem.dmem_req_valid, s2_ready}); end
  endtask

  task automatic test_alu();
    issue(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd7, 1'b1);
    checks++; if (s3_valid !== 1'b1) begin failures++; $display("FAIL alu_valid got=%b exp=1", s3_valid); end
    checks++; if (s3_rdata !== 32'h1234) begin failures++; $display("FAIL alu_rdata got=%h exp=00001234", s3_rdata); end
    checks++; if ({s3_rdata_sel, s3_reg_we, s3_rd, s3_fault} !== {3'd0, 1'b1, 5'd7, 1'b0}) begin failures++; $display("FAIL alu_fields got=%h exp=%h", {s3_rdata_sel, s3_reg_we, s3_rd, s3_fault}, {3'd0, 1'b1, 5'd7, 1'b0}); end
    cyc();
    checks++; if ({s3_valid, s3_rdata} !== {1'b0, 32'h1234}) begin failures++; $display("FAIL alu_pulse got=%h exp=000001234", {s3_valid, s3_rdata}); end
  endtask

  task automatic test_load_lbu();
    issue(1'b1, 1'b0, F3_LBU, 32'h103, 32'h0, 5'd9, 1'b1);
    checks++; if ({dmem.dmem_req_valid, dmem.dmem_req_addr, dmem.dmem_req_we, s2_ready} !== {1'b1, 32'h100, 1'b0, 1'b0}) begin failures++; $display("FAIL lbu_req got=%h exp=%h", {dmem.dmem_req_valid, dmem.dmem_req_addr, dmem.dmem_req_we, s2_ready}, {1'b1, 32'h100, 1'b0, 1'b0}); end
    cyc();
    checks++; if ({dmem.dmem_req_valid, dmem.dmem_req_addr} !== {1'b1, 32'h100}) begin failures++; $display("FAIL lbu_req_hold got=%h exp=100000100", {dmem.dmem_req_valid, dmem.dmem_req_addr}); end
    dmem.dmem_req_ready = 1'b1;
    cyc();
    dmem.dmem_req_ready = 1'b0;
    checks++; if ({dmem.dmem_req_valid, s3_valid, s2_ready} !== 3'b000) begin failures++; $display("FAIL lbu_wait got=%b exp=000", {dmem.dmem_req_valid, s3_valid, s2_ready}); end
    cyc(); cyc();
    dmem.dmem_resp_valid = 1'b1; dmem.dmem_resp_data = 32'hAABBCCDD;
    cyc();
    dmem.dmem_resp_valid = 1'b0;
    checks++; if ({s3_valid, s3_rdata} !== {1'b1, 32'hAABBCCDD}) begin failures++; $display("FAIL lbu_data got=%h exp=1aabbccdd", {s3_valid, s3_rdata}); end
    checks++; if ({s3_rdata_sel, byte_select, s3_reg_we, s3_rd} !== {3'd1, 2'd3, 1'b1, 5'd9}) begin failures++; $display("FAIL lbu_fields got=%h exp=%h", {s3_rdata_sel, byte_select, s3_reg_we, s3_rd}, {3'd1, 2'd3, 1'b1, 5'd9}); end
    cyc();
    checks++; if ({s3_valid, s3_rdata, s2_ready} !== {1'b0, 32'hAABBCCDD, 1'b1}) begin failures++; $display("FAIL lbu_after got=%h exp=%h", {s3_valid, s3_rdata, s2_ready}, {1'b0, 32'hAABBCCDD, 1'b1}); end
  endtask

  task automatic test_store_sh();
    issue(1'b0, 1'b1, F3_SH, 32'h22, 32'h0000BEEF, 5'd3, 1'b1);
    checks++; if ({dmem.dmem_req_valid, dmem.dmem_req_addr, dmem.dmem_req_we} !== {1'b1, 32'h20, 1'b1}) begin failures++; $display("FAIL sh_req got=%h exp=%h", {dmem.dmem_req_valid, dmem.dmem_req_addr, dmem.dmem_req_we}, {1'b1, 32'h20, 1'b1}); end
    checks++; if ({dmem.dmem_req_wdata, dmem.dmem_req_wmask} !== {32'hBEEFBEEF, 4'b1100}) begin failures++; $display("FAIL sh_data got=%h exp=beefbeefc", {dmem.dmem_req_wdata, dmem.dmem_req_wmask}); end
    dmem.dmem_req_ready = 1'b1;
    cyc();
    dmem.dmem_req_ready = 1'b0;
    checks++; if ({s3_valid, s3_reg_we, s3_fault, dmem.dmem_req_valid, s2_ready} !== 5'b10001) begin failures++; $display("FAIL sh_done got=%b exp=10001", {s3_valid, s3_reg_we, s3_fault, dmem.dmem_req_valid, s2_ready}); end
  endtask

  task automatic test_store_sb();
    issue(1'b0, 1'b1, F3_SB, 32'h1, 32'h12345678, 5'd3, 1'b0);
    checks++; if ({dmem.dmem_req_wdata, dmem.dmem_req_wmask, dmem.dmem_req_addr} !== {32'h78787878, 4'b0010, 32'h0}) begin failures++; $display("FAIL sb_data got=%h exp=%h", {dmem.dmem_req_wdata, dmem.dmem_req_wmask, dmem.dmem_req_addr}, {32'h78787878, 4'b0010, 32'h0}); end
    dmem.dmem_req_ready = 1'b1;
    cyc();
    dmem.dmem_req_ready = 1'b0;
    checks++; if ({s3_valid, s3_reg_we} !== 2'b10) begin failures++; $display("FAIL sb_done got=%b exp=10", {s3_valid, s3_reg_we}); end
  endtask

  task automatic test_load_lb_overlap();
    issue(1'b1, 1'b0, F3_LB, 32'h102, 32'h0, 5'd4, 1'b1);
    dmem.dmem_req_ready = 1'b1; dmem.dmem_resp_valid = 1'b1; dmem.dmem_resp_data = 32'h11111111;
    cyc();
    dmem.dmem_req_ready = 1'b0; dmem.dmem_resp_valid = 1'b0;
    checks++; if ({s3_valid, dmem.dmem_req_valid, s2_ready} !== 3'b000) begin failures++; $display("FAIL lb_hs_resp got=%b exp=000", {s3_valid, dmem.dmem_req_valid, s2_ready}); end
    dmem.dmem_resp_valid = 1'b1; dmem.dmem_resp_data = 32'h80FF7F01;
    cyc();
    dmem.dmem_resp_valid = 1'b0;
    checks++; if ({s3_valid, s3_rdata, s3_rdata_sel, byte_select, s3_rd} !== {1'b1, 32'h80FF7F01, 3'd2, 2'd2, 5'd4}) begin failures++; $display("FAIL lb_done got=%h exp=%h", {s3_valid, s3_rdata, s3_rdata_sel, byte_select, s3_rd}, {1'b1, 32'h80FF7F01, 3'd2, 2'd2, 5'd4}); end
    dmem.dmem_resp_valid = 1'b1; dmem.dmem_resp_data = 32'h55555555;
    cyc();
    dmem.dmem_resp_valid = 1'b0;
    checks++; if ({s3_valid, s3_rdata} !== {1'b0, 32'h80FF7F01}) begin failures++; $display("FAIL idle_resp got=%h exp=080ff7f01", {s3_valid, s3_rdata}); end
  endtask

  task automatic test_fault();
    issue(1'b0, 1'b0, 3'b000, 32'h77, 32'h0, 5'd1, 1'b1);
    issue(1'b1, 1'b0, F3_LW, 32'h41, 32'h0, 5'd6, 1'b1);
    checks++; if ({dmem.dmem_req_valid, s3_valid, s3_fault, s3_reg_we, s2_ready} !== 5'b01101) begin failures++; $display("FAIL lw_misalign got=%b exp=01101", {dmem.dmem_req_valid, s3_valid, s3_fault, s3_reg_we, s2_ready}); end
    cyc();
    checks++; if ({s3_valid, s3_fault} !== 2'b00) begin failures++; $display("FAIL fault_pulse got=%b exp=00", {s3_valid, s3_fault}); end
    issue(1'b1, 1'b1, F3_LW, 32'h40, 32'h0, 5'd6, 1'b1);
    checks++; if ({dmem.dmem_req_valid, s3_valid, s3_fault} !== 3'b011) begin failures++; $display("FAIL both_ops got=%b exp=011", {dmem.dmem_req_valid, s3_valid, s3_fault}); end
    issue(1'b0, 1'b1, 3'b100, 32'h40, 32'h0, 5'd6, 1'b0);
    checks++; if ({dmem.dmem_req_valid, s3_valid, s3_fault} !== 3'b011) begin failures++; $display("FAIL bad_f3 got=%b exp=011", {dmem.dmem_req_valid, s3_valid, s3_fault}); end
    issue(1'b1, 1'b0, F3_LH, 32'h43, 32'h0, 5'd6, 1'b1);
    checks++; if ({dmem.dmem_req_valid, s3_valid, s3_fault} !== 3'b011) begin failures++; $display("FAIL lh_misalign got=%b exp=011", {dmem.dmem_req_valid, s3_valid, s3_fault}); end
    issue(1'b1, 1'b0, F3_LH, 32'h42, 32'h0, 5'd6, 1'b1);
    checks++; if ({dmem.dmem_req_valid, s3_fault} !== 2'b10) begin failures++; $display("FAIL lh_aligned got=%b exp=10", {dmem.dmem_req_valid, s3_fault}); end
    dmem.dmem_req_ready = 1'b1;
    cyc();
    dmem.dmem_req_ready = 1'b0;
    dmem.dmem_resp_valid = 1'b1; dmem.dmem_resp_data = 32'h0000ABCD;
    cyc();
    dmem.dmem_resp_valid = 1'b0;
    checks++; if ({s3_valid, s3_rdata_sel, byte_select} !== {1'b1, 3'd4, 2'd2}) begin failures++; $display("FAIL lh_done got=%h exp=%h", {s3_valid, s3_rdata_sel, byte_select}, {1'b1, 3'd4, 2'd2}); end
  endtask

  task automatic test_reset_in_wait();
    issue(1'b1, 1'b0, F3_LW, 32'h40, 32'h0, 5'd2, 1'b1);
    dmem.dmem_req_ready = 1'b1;
    cyc();
    dmem.dmem_req_ready = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    dmem.dmem_resp_valid = 1'b1; dmem.dmem_resp_data = 32'hDEADBEEF;
    cyc();
    dmem.dmem_resp_valid = 1'b0;
    checks++; if ({s3_valid, s2_ready, dmem.dmem_req_valid} !== 3'b010) begin failures++; $display("FAIL rst_wait got=%b exp=010", {s3_valid, s2_ready, dmem.dmem_req_valid}); end
    checks++; if (s3_rdata !== 32'h0) begin failures++; $display("FAIL rst_wait_rdata got=%h exp=00000000", s3_rdata); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      s2_valid = 1'b1; s2_is_load = 1'b0; s2_is_store = 1'b0; s2_addr = 32'h200 + i; s2_rd = 5'(i + 1); s2_reg_we = 1'b1;
      checks++; if (s2_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready%0d got=%b exp=1", i, s2_ready); end
      cyc();
      checks++; if ({s3_valid, s3_rdata, s3_rd} !== {1'b1, 32'h200 + 32'(i), 5'(i + 1)}) begin failures++; $display("FAIL b2b_out%0d got=%h exp=%h", i, {s3_valid, s3_rdata, s3_rd}, {1'b1, 32'h200 + 32'(i), 5'(i + 1)}); end
    end
    s2_valid = 1'b0;
    cyc();
    checks++; if (s3_valid !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b exp=0", s3_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_alu();
    test_load_lbu();
    test_store_sh();
    test_store_sb();
    test_load_lb_overlap();
    test_fault();
    test_reset_in_wait();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter: CPU_DATA_BITS, default 32 (from const.vh), datapath width; only 32 is supported.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 s2_valid  in  1  execute stage presents an instruction.
REQ-005 s2_ready  out  1  stage accepts the instruction this cycle.
REQ-006 s2_is_load / s2_is_store  in  1 each  memory op type; both low means ALU op; both high is illegal.
REQ-007 s2_funct3  in  3  RISC-V width code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-008 s2_addr  in  32  effective address, or ALU result for non-memory ops.
REQ-009 s2_wdata  in  32  store source register value.
REQ-010 s2_rd  in  5  destination register; s2_reg_we  in  1  instruction writes rd.
REQ-011 dmem_req_valid out 1; dmem_req_ready in 1; dmem_req_addr out 32; dmem_req_we out 1; dmem_req_wdata out 32; dmem_req_wmask out 4.
REQ-012 dmem_resp_valid in 1; dmem_resp_data in 32.
REQ-013 s3_valid out 1; s3_rdata out 32; s3_rdata_sel out 3; byte_select out 2; s3_rd out 5; s3_reg_we out 1; s3_fault out 1.

Function
REQ-014 FSM states IDLE, REQ, WAIT; s2_ready = (state == IDLE).
REQ-015 IDLE, s2_valid, ALU op: s3 outputs loaded next edge (latency 1): s3_rdata = s2_addr, s3_rdata_sel = PASSTHROUGH, s3_reg_we = s2_reg_we, s3_valid = 1; stay IDLE.
REQ-016 IDLE, s2_valid, aligned load/store: latch op, go to REQ.
REQ-017 REQ: dmem_req_valid = 1, request fields stable until dmem_req_ready; on handshake, load -> WAIT, store -> IDLE with s3_valid = 1, s3_reg_we = 0 next cycle.
REQ-018 WAIT: on dmem_resp_valid, s3_rdata = dmem_resp_data, s3_reg_we = latched reg_we, s3_valid = 1 next cycle; -> IDLE.
REQ-019 dmem_resp_valid outside WAIT is ignored; response never counted in the cycle of the request handshake.
REQ-020 dmem_req_addr = {addr[31:2], 2'b00}; byte_select = addr[1:0] for loads, 0 otherwise.
REQ-021 Load sel mapping (const.vh codes): LB->LOW_BYTE_SIGNED, LH->LOW_HALF_WORD_SIGNED, LW->PASSTHROUGH, LBU->LOW_BYTE, LHU->LOW_HALF_WORD.
REQ-022 Store data: SB = wdata[7:0] replicated x4, mask 4'b0001 << addr[1:0]; SH = wdata[15:0] replicated x2, mask 4'b0011 << addr[1:0]; SW = wdata, mask 4'b1111; dmem_req_we = 1 for stores only.
REQ-023 Misaligned (H with addr[0]=1; W with addr[1:0]!=0), undefined funct3, or load+store both high: no dmem request; next cycle s3_valid = 1, s3_fault = 1, s3_reg_we = 0; stay IDLE.
REQ-024 s3_valid and s3_fault are single-cycle pulses; other s3 outputs hold last value.
REQ-025 No downstream backpressure; at most one instruction in flight.

Reset
REQ-026 reset -> state IDLE, dmem_req_valid 0, s3_valid 0, s3_fault 0, s3_reg_we 0, s3_rdata 0, s3_rdata_sel PASSTHROUGH, byte_select 0, s3_rd 0.
REQ-027 reset in REQ/WAIT abandons the op; a later stale response is ignored (IDLE).

Structure
REQ-028 S3_RDATA_SEL_* codes (PASSTHROUGH=0, LOW_BYTE=1, LOW_BYTE_SIGNED=2, LOW_HALF_WORD=3, LOW_HALF_WORD_SIGNED=4), funct3 codes and FSM encodings live in const.vh.
REQ-029 One sub-module, store_align (combinational wdata/wmask/misalign generation); FSM and s3 registers in top.

Verification
REQ-030 ALU op addr=0x1234, reg_we=1 -> 1 cycle later s3_valid, s3_rdata=0x1234, sel=PASSTHROUGH.
REQ-031 LBU addr=0x103, ready after 2 cycles, resp 0xAABBCCDD after 3 more -> req addr 0x100, s3_rdata=0xAABBCCDD, sel=LOW_BYTE, byte_select=3.
REQ-032 SH addr=0x22, wdata=0x0000BEEF -> wdata=0xBEEFBEEF, wmask=4'b1100, we=1, s3_valid with reg_we=0 after handshake.
REQ-033 LW addr=0x41 -> no dmem_req_valid, s3_fault pulse, s3_reg_we=0.
REQ-034 Reset asserted in WAIT, resp arrives next cycle -> no s3_valid, state IDLE, s2_ready=1.
REQ-035 Back-to-back ALU ops with s2_valid held -> one s3_valid per cycle, s2_ready never drops.
